// File: rtl/mod_mul_25519.sv
// Iterative GF(2^255 - 19) multiplier: MSB-first interleaved double-and-add, one bit of b per clock.
// Start/done handshake with busy flag; result is registered and always fully reduced.
module mod_mul_25519 #(
    parameter int unsigned      WIDTH = 255,
    parameter logic [WIDTH-1:0] PRIME =
        255'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [7:0]       cnt;

    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_red;
    logic             b_bit;

    // Every intermediate stays below 2p, so one conditional subtract per step keeps acc < p.
    always_comb begin
        p_ext    = {1'b0, PRIME};
        a_red    = (a >= PRIME) ? a - PRIME : a;
        b_bit    = b_reg[cnt];
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum      = dbl_red + (b_bit ? {1'b0, a_reg} : '0);
        acc_next = (sum >= p_ext) ? WIDTH'(sum - p_ext) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        a_reg <= a_red;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= 8'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    acc <= acc_next;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_25519.sv
// Self-checking bench for mod_mul_25519: directed corner cases, handshake scenarios
// and randomized operands against a wide-integer a*b mod p reference.
module tb_mod_mul_25519;

    localparam logic [254:0] P =
        255'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic [254:0] result;
    logic         done;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_mul_25519 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
        logic [511:0] prod;
        prod = {257'b0, x} * {257'b0, y};
        return 255'(prod % {257'b0, P});
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
        case ($urandom_range(0, 3))
            1: v[254:8] = '1;           // near or above p
            2: v = v & 256'hFF;
            default: ;
        endcase
        return v[254:0];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps cycles until done (bounded); busy must stay high on every cycle before done.
    task automatic wait_done(input int n0, output int n, output int busy_bad);
        n = n0;
        busy_bad = 0;
        do begin
            tick();
            n++;
            if (!done && !busy) busy_bad++;
        end while (!done && n < 400);
    endtask

    task automatic do_op(input string tag, input logic [254:0] x, input logic [254:0] y,
                         input logic [254:0] exp);
        int n;
        int bb;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        check({tag, "_busy_start"}, 256'(busy), 256'(1));
        start = 1'b0;
        a = rand255();
        b = rand255();
        wait_done(0, n, bb);
        check({tag, "_latency"}, 256'(n), 256'(255));
        check({tag, "_result"}, 256'(result), 256'(exp));
        check({tag, "_lt_p"}, 256'(result < P), 256'(1));
        check({tag, "_busy_run"}, 256'(bb), 256'(0));
        check({tag, "_busy_done"}, 256'(busy), 256'(0));
        tick();
        check({tag, "_done_width"}, 256'(done), 256'(0));
        check({tag, "_result_hold"}, 256'(result), 256'(exp));
    endtask

    initial begin
        int n;
        int bb;
        int extra;
        logic [254:0] x1, y1, x2, y2;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("rst_result", 256'(result), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        rst = 1'b0;
        tick();

        do_op("basic", 255'd2, 255'd3, 255'd6);
        do_op("pm1_sq", P - 255'd1, P - 255'd1, 255'd1);
        do_op("pow254x2", 255'd1 << 254, 255'd2, 255'd19);
        do_op("zero_a", 255'd0, P - 255'd1, 255'd0);
        do_op("a_eq_p", P, 255'd5, 255'd0);
        do_op("a_all1", '1, 255'd1, 255'd18);

        // start pulsed mid-run with other operands must be ignored
        x1 = rand255();
        y1 = rand255();
        a = x1;
        b = y1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        a = rand255();
        b = rand255();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(51, n, bb);
        check("ign_latency", 256'(n), 256'(255));
        check("ign_result", 256'(result), 256'(ref_mul(x1, y1)));
        extra = 0;
        repeat (300) begin
            tick();
            if (done) extra++;
        end
        check("ign_extra_done", 256'(extra), 256'(0));
        check("ign_idle", 256'(busy), 256'(0));

        // start held high through the done cycle: back-to-back, 256 cycles apart
        x1 = rand255();
        y1 = rand255();
        x2 = rand255();
        y2 = rand255();
        a = x1;
        b = y1;
        start = 1'b1;
        tick();
        a = x2;
        b = y2;
        wait_done(0, n, bb);
        check("b2b_first_lat", 256'(n), 256'(255));
        check("b2b_first_res", 256'(result), 256'(ref_mul(x1, y1)));
        tick();
        start = 1'b0;
        check("b2b_reaccept", 256'(busy), 256'(1));
        check("b2b_done_width", 256'(done), 256'(0));
        wait_done(1, n, bb);
        check("b2b_spacing", 256'(n), 256'(256));
        check("b2b_second_res", 256'(result), 256'(ref_mul(x2, y2)));
        tick();

        // reset mid-run aborts with no done
        a = rand255();
        b = rand255();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_result", 256'(result), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        rst = 1'b0;
        extra = 0;
        repeat (260) begin
            tick();
            if (done) extra++;
        end
        check("midrst_no_done", 256'(extra), 256'(0));
        do_op("after_rst", 255'd7, 255'd11, 255'd77);

        for (int i = 0; i < 200; i++) begin
            x1 = rand255();
            y1 = rand255();
            do_op("rand", x1, y1, ref_mul(x1, y1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
